// File: rtl/stack_spill_ctrl.sv
// stack_spill_ctrl: register save/restore sequencer in front of the CPU
// hardware stack. It walks a register mask, pushing registers (ascending)
// or popping them back into the register file (descending). When idle it
// also passes direct CPU push/pop strobes through to the stack.
// Optional feature macro: STACK_SPILL_BOUNDS_EN enables the occupancy
// counter, the full/empty checks, the sticky error flags and abort-on-error.
//
// Handshake: save_req/restore_req are sampled only while idle. A request
// is accepted on the first rising edge where it is high in IDLE, and busy
// rises on the following cycle. There is no ready output: requests seen
// outside IDLE are ignored, not queued. done pulses for one cycle at the end.
module stack_spill_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int NREG   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     save_req,
  input  logic                     restore_req,
  input  logic [NREG-1:0]          reg_mask,
  output logic                     busy,
  output logic                     done,
  output logic                     err_ovf,
  output logic                     err_unf,
  output logic [7:0]               count,
  input  logic                     cpu_push,
  input  logic                     cpu_pop,
  input  logic [DATA_W-1:0]        cpu_d,
  output logic [$clog2(NREG)-1:0]  rf_raddr,
  input  logic [DATA_W-1:0]        rf_rdata,
  output logic                     rf_we,
  output logic [$clog2(NREG)-1:0]  rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     stk_push,
  output logic                     stk_pop,
  output logic [DATA_W-1:0]        stk_d,
  input  logic [DATA_W-1:0]        stk_q,
  output logic [2:0]               dbg_state
);

  localparam int IW = $clog2(NREG);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SAVE_RD   = 3'd1,
    SAVE_PUSH = 3'd2,
    RESTORE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [NREG-1:0]   mask, mask_nxt;
  logic              push_nxt, pop_nxt, pop_rf, pop_rf_nxt;
  logic [DATA_W-1:0] push_d_nxt;
  logic [IW-1:0]     pop_addr, pop_addr_nxt;
  logic              inc, dec, set_ovf, set_unf, clr_err;
  logic              full, empty;

  assign dbg_state = state;
  // Read address is presented in SAVE_RD so data arrives during SAVE_PUSH.
  assign rf_raddr  = (state == SAVE_RD) ? idx : '0;

  // Next-state, strobe decisions and occupancy/error events.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    mask_nxt     = mask;
    push_nxt     = 1'b0;
    push_d_nxt   = stk_d;
    pop_nxt      = 1'b0;
    pop_rf_nxt   = 1'b0;
    pop_addr_nxt = pop_addr;
    inc          = 1'b0;
    dec          = 1'b0;
    set_ovf      = 1'b0;
    set_unf      = 1'b0;
    clr_err      = 1'b0;
    unique case (state)
      IDLE: begin
        if (save_req) begin
          mask_nxt  = reg_mask;
          idx_nxt   = IW'(1);
          clr_err   = 1'b1;
          state_nxt = SAVE_RD;
        end else if (restore_req) begin
          mask_nxt  = reg_mask;
          idx_nxt   = IW'(NREG - 1);
          clr_err   = 1'b1;
          state_nxt = RESTORE;
        end else if (cpu_push) begin
          if (full) begin
            set_ovf = 1'b1;
          end else begin
            push_nxt   = 1'b1;
            push_d_nxt = cpu_d;
            inc        = 1'b1;
          end
        end else if (cpu_pop) begin
          if (empty) set_unf = 1'b1;
          else begin
            pop_nxt = 1'b1;
            dec     = 1'b1;
          end
        end
      end
      SAVE_RD: begin
        if (mask[idx])                 state_nxt = SAVE_PUSH;
        else if (idx == IW'(NREG - 1)) state_nxt = DONE;
        else                           idx_nxt   = idx + IW'(1);
      end
      SAVE_PUSH: begin
        if (full) begin
          set_ovf   = 1'b1;
          state_nxt = DONE;
        end else begin
          push_nxt   = 1'b1;
          push_d_nxt = rf_rdata;
          inc        = 1'b1;
          if (idx == IW'(NREG - 1)) state_nxt = DONE;
          else begin
            idx_nxt   = idx + IW'(1);
            state_nxt = SAVE_RD;
          end
        end
      end
      RESTORE: begin
        if (mask[idx] && empty) begin
          set_unf   = 1'b1;
          state_nxt = DONE;
        end else begin
          if (mask[idx]) begin
            pop_nxt      = 1'b1;
            pop_rf_nxt   = 1'b1;
            pop_addr_nxt = idx;
            dec          = 1'b1;
          end
          if (idx == IW'(1)) state_nxt = DONE;
          else               idx_nxt   = idx - IW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, registered strobes, and the register-file write that captures
  // the top of stack during the cycle its pop strobe is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      mask     <= '0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      stk_d    <= '0;
      pop_rf   <= 1'b0;
      pop_addr <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      mask     <= mask_nxt;
      stk_push <= push_nxt;
      stk_pop  <= pop_nxt;
      stk_d    <= push_d_nxt;
      pop_rf   <= pop_rf_nxt;
      pop_addr <= pop_addr_nxt;
      rf_we    <= stk_pop & pop_rf;
      if (stk_pop && pop_rf) begin
        rf_waddr <= pop_addr;
        rf_wdata <= stk_q;
      end
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
    end
  end

`ifdef STACK_SPILL_BOUNDS_EN
  localparam logic [7:0] DEPTH_C = 8'(DEPTH);

  assign full  = (count == DEPTH_C);
  assign empty = (count == 8'd0);

  // Occupancy counter and sticky error flags, cleared on request accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 8'd0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (inc)      count <= count + 8'd1;
      else if (dec) count <= count - 8'd1;
      if (clr_err) begin
        err_ovf <= 1'b0;
        err_unf <= 1'b0;
      end else begin
        if (set_ovf) err_ovf <= 1'b1;
        if (set_unf) err_unf <= 1'b1;
      end
    end
  end
`else
  // Without bounds tracking the stack pointer simply wraps.
  logic unused_bounds;
  assign full          = 1'b0;
  assign empty         = 1'b0;
  assign count         = 8'd0;
  assign err_ovf       = 1'b0;
  assign err_unf       = 1'b0;
  assign unused_bounds = ^{inc, dec, set_ovf, set_unf, clr_err, 8'(DEPTH)};
`endif

endmodule
